// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, colour slicing and test-bar palette.
// VGA_TEST_PATTERN_EN adds the delayed x field used by the bar generator.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int COLOR_W = 30;
  localparam int COMP_W  = 10;
  localparam int R_MSB   = 29;
  localparam int R_LSB   = 20;
  localparam int G_MSB   = 19;
  localparam int G_LSB   = 10;
  localparam int B_MSB   = 9;
  localparam int B_LSB   = 0;

  localparam int BAR_W = 80;

  localparam logic [COLOR_W-1:0] BAR_WHITE   = 30'h3FFF_FFFF;
  localparam logic [COLOR_W-1:0] BAR_YELLOW  = 30'h3FFF_FC00;
  localparam logic [COLOR_W-1:0] BAR_CYAN    = 30'h000F_FFFF;
  localparam logic [COLOR_W-1:0] BAR_GREEN   = 30'h000F_FC00;
  localparam logic [COLOR_W-1:0] BAR_MAGENTA = 30'h3FF0_03FF;
  localparam logic [COLOR_W-1:0] BAR_RED     = 30'h3FF0_0000;
  localparam logic [COLOR_W-1:0] BAR_BLUE    = 30'h0000_03FF;
  localparam logic [COLOR_W-1:0] BAR_BLACK   = 30'h0000_0000;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
`ifdef VGA_TEST_PATTERN_EN
    logic [9:0] x;
`endif
  } sync_t;

  localparam sync_t SYNC_IDLE = '{blank: 1'b1, default: '0};

  function automatic logic [COLOR_W-1:0] bar_color(
    input logic [9:0] x
  );
    logic [9:0] idx;
    idx = x / 10'(BAR_W);
    case (idx)
      10'd0:   bar_color = BAR_WHITE;
      10'd1:   bar_color = BAR_YELLOW;
      10'd2:   bar_color = BAR_CYAN;
      10'd3:   bar_color = BAR_GREEN;
      10'd4:   bar_color = BAR_MAGENTA;
      10'd5:   bar_color = BAR_RED;
      10'd6:   bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Raster h/v counters, stage-0 position issue, sync decode, frame_start.
// VGA_TEST_PATTERN_EN also forwards the raw h count for bar alignment.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce_i,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       en_o,
  output sync_t      raw_o,
  output logic       frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [9:0] x_q, y_q;
  logic       en_q, fs_q;
  logic       active;
  logic       at_origin;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (ce_i) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  assign active = ({1'b0, h_q} < 11'(H_ACTIVE)) &&
                  ({1'b0, v_q} < 11'(V_ACTIVE));
  assign at_origin = (h_q == '0) && (v_q == '0);

  always_comb begin
    raw_o       = SYNC_IDLE;
    raw_o.hs    = (h_q >= HS_BEG) && (h_q <= HS_END);
    raw_o.vs    = (v_q >= VS_BEG) && (v_q <= VS_END);
    raw_o.blank = !active;
`ifdef VGA_TEST_PATTERN_EN
    raw_o.x     = h_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q  <= '0;
      v_q  <= '0;
      x_q  <= '0;
      y_q  <= '0;
      en_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      // pulse rides with the issue of (0,0), cleared on the next clk
      fs_q <= ce_i && at_origin;
      if (ce_i) begin
        x_q  <= h_q;
        y_q  <= v_q;
        en_q <= active;
      end
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign en_o          = en_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_output_stage.sv
// VGA output stage: raster issue, sync/blank alignment, DAC drive.
// VGA_TEST_PATTERN_EN adds test_mode selecting 8 vertical colour bars.
module vga_output_stage
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int COLOR_LAT = 1,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               px_ce,
  input  logic [COLOR_W-1:0] color_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               enable,
  output logic [COMP_W-1:0]  vga_r,
  output logic [COMP_W-1:0]  vga_g,
  output logic [COMP_W-1:0]  vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
      COLOR_LAT < 1 || COLOR_LAT > 4) begin : g_bad_cfg
    $error("vga_output_stage: illegal timing or COLOR_LAT");
  end

  sync_t              raw;
  sync_t              tail;
  sync_t              pipe_q [COLOR_LAT];
  logic [COLOR_W-1:0] src;
  logic [COLOR_W-1:0] rgb_d, rgb_q;
  logic               hs_q, vs_q, blank_q;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_cnt (
    .clk_i         (clk),
    .rst_i         (rst),
    .ce_i          (px_ce),
    .x_o           (x),
    .y_o           (y),
    .en_o          (enable),
    .raw_o         (raw),
    .frame_start_o (frame_start)
  );

  // tail is the sync/blank whose colour is on color_data right now
  assign tail = pipe_q[COLOR_LAT-1];

  always_comb begin
    src = color_data;
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) src = bar_color(tail.x);
`endif
    rgb_d = tail.blank ? '0 : src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COLOR_LAT; i++) pipe_q[i] <= SYNC_IDLE;
      rgb_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b1;
    end else if (px_ce) begin
      pipe_q[0] <= raw;
      for (int i = 1; i < COLOR_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      rgb_q   <= rgb_d;
      hs_q    <= tail.hs;
      vs_q    <= tail.vs;
      blank_q <= tail.blank;
    end
  end

  assign vga_r     = rgb_q[R_MSB:R_LSB];
  assign vga_g     = rgb_q[G_MSB:G_LSB];
  assign vga_b     = rgb_q[B_MSB:B_LSB];
  assign vga_hs    = hs_q ^ ~SYNC_POL;
  assign vga_vs    = vs_q ^ ~SYNC_POL;
  assign vga_blank = blank_q;

endmodule
